nonce_result_arbiter: RTL and testbench
=======================================

Name: nonce_result_arbiter

Overview:
- Collects golden-nonce results from NCORES pbkdfengine/salsaengine core pairs and queues them for host readout.
- Replaces the fixed two-register golden_nonce_a/b capture in the top level; simultaneous matches from several cores are never silently lost.
- Per-core pending latch -> round-robin arbiter -> small FIFO read by the outbuf loader, with a drop counter for diagnostics.
- Sits in the hash_clk domain between the cores' golden_nonce_match/golden_nonce_out and the host output shift buffer.

Parameters:
- NCORES, 2, number of cores (1..8).
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- CORE_BITS, max(1,clog2(NCORES)), width of the core index (derived localparam).

Ports:
- hash_clk  in  1  core clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state including drop_count.
- flush  in  1  new-work strobe (loadnonce); clears pending latches, FIFO and rr_ptr; does not clear drop_count.
- gn_match  in  NCORES  per-core single-cycle match strobe.
- golden_nonce_in  in  32*NCORES  core i nonce at bits [32i+31:32i]; valid when gn_match[i]=1.
- pop  in  1  consume head entry; ignored when nonce_valid=0.
- nonce_valid  out  1  FIFO not empty.
- nonce_out  out  32  head entry nonce; 0 when empty.
- core_id  out  CORE_BITS  head entry source core; 0 when empty.
- fifo_count  out  clog2(DEPTH)+1  occupancy, 0..DEPTH.
- drop_count  out  8  saturating count of discarded matches.

Behaviour:
- Reset, synchronous, takes priority over everything:
  - pending=0, rr_ptr=0, FIFO empty.
  - nonce_valid=0, nonce_out=0, core_id=0, fifo_count=0, drop_count=0.
- Flush (reset low):
  - Same clears as reset except drop_count holds.
  - gn_match and pop in the flush cycle are ignored and are not counted as drops.
- Pending stage, per core i, registered:
  - gn_match[i]=1 and pending[i]=0: pending[i]<=1, pnonce[i]<=golden_nonce_in[i].
  - gn_match[i]=1 and pending[i]=1, with core i not granted this cycle: the new nonce is discarded, pnonce[i] holds, drop_count+1.
  - gn_match[i]=1 with core i granted this cycle: pending[i] stays 1, pnonce[i] takes the new nonce, no drop.
- Arbitration, combinational on the registered pending bits:
  - space = (fifo_count<DEPTH) | (pop & nonce_valid).
  - If space and any pending bit: grant the first set bit searching rr_ptr, rr_ptr+1, ... modulo NCORES.
  - On grant: push {g, pnonce[g]}, clear pending[g] unless re-set in the same cycle, rr_ptr<=(g+1) mod NCORES.
  - No space: nothing granted; pending bits hold.
  - At most one push per cycle.
- FIFO:
  - Circular buffer, wr/rd pointers wrap modulo DEPTH.
  - Push and pop in the same cycle at full is legal: count stays DEPTH, and the head advances.
  - Push and pop in the same cycle at count=1: the new entry becomes head the next cycle.
  - Outputs are driven from the registered head entry (zero when empty).
- Latency:
  - gn_match at edge t -> pending at t -> push at edge t+1 -> nonce_valid=1 after edge t+1, i.e. 2 cycles when the FIFO has space.
  - Pop at edge t: count decrements at t; the next head appears at t.
- drop_count saturates at 255. Increments from several cores in the same cycle add their sum, then saturate.
- NCORES=1: rr_ptr is constant 0; core_id is always 0.

Test Plan:
1. Reset, then gn_match=2'b01, nonce0=32'h0000318f -> nonce_valid=1 two cycles later, nonce_out=32'h0000318f, core_id=0, fifo_count=1; pop -> nonce_valid=0, nonce_out=0.
2. gn_match=2'b11 same cycle, nonce0=A, nonce1=B, rr_ptr=0 -> FIFO order A(core 0) then B(core 1); rr_ptr ends 0; drop_count=0.
3. Repeat scenario 2 with rr_ptr=1 (preceded by a single core-0 hit) -> order B then A after the earlier entry.
4. With no pops, 6 single hits alternating cores at 3-cycle spacing, DEPTH=4 -> fifo_count=4. One core's 5th hit stays pending; the 6th hit on the same core increments drop_count to 1. A pop at full pushes the pending entry the same cycle, and count stays 4.
5. Hit on core 0 two consecutive cycles while the FIFO has space -> both nonces queued in order, drop_count=0.
6. Fill FIFO to 3 entries plus one pending, then pulse flush together with gn_match=2'b10 -> fifo_count=0, nonce_valid=0, pending=0, drop_count unchanged; a later reset clears drop_count to 0.

Source files
------------

// File: rtl/nonce_result_arbiter.sv
// nonce_result_arbiter: per-core golden-nonce latches feeding a round-robin
// arbiter and a small FIFO for host readout, with a saturating drop counter.
module nonce_result_arbiter #(
  parameter int NCORES = 2,
  parameter int DEPTH  = 4,
  localparam int CORE_BITS = (NCORES > 1) ? $clog2(NCORES) : 1,
  localparam int PTR_BITS  = $clog2(DEPTH),
  localparam int CNT_BITS  = $clog2(DEPTH) + 1
) (
  input  logic                   hash_clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [NCORES-1:0]      gn_match,
  input  logic [32*NCORES-1:0]   golden_nonce_in,
  input  logic                   pop,
  output logic                   nonce_valid,
  output logic [31:0]            nonce_out,
  output logic [CORE_BITS-1:0]   core_id,
  output logic [CNT_BITS-1:0]    fifo_count,
  output logic [7:0]             drop_count
);

  typedef struct packed {
    logic [CORE_BITS-1:0] core;
    logic [31:0]          nonce;
  } entry_t;

  logic [NCORES-1:0]    pending_q, pending_d;
  logic [31:0]          pnonce_q [NCORES];
  logic [31:0]          pnonce_d [NCORES];
  logic [CORE_BITS-1:0] rr_q, rr_d;
  logic [PTR_BITS-1:0]  wr_q, wr_d;
  logic [PTR_BITS-1:0]  rd_q, rd_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [7:0]           drop_q, drop_d;
  entry_t               mem_q [DEPTH];

  logic                 pop_eff;
  logic                 space;
  logic                 push;
  logic [CORE_BITS-1:0] grant_idx;
  logic [3:0]           drops;
  logic [8:0]           drop_sum;
  entry_t               push_ent;
  entry_t               head;

  assign nonce_valid = (cnt_q != '0);
  assign pop_eff     = pop & nonce_valid;
  assign space       = (cnt_q < CNT_BITS'(DEPTH)) | pop_eff;

  // Lowest offset from rr_q wins; scanning downward lets it overwrite last.
  always_comb begin
    push      = 1'b0;
    grant_idx = '0;
    for (int k = NCORES - 1; k >= 0; k--) begin
      if (pending_q[(int'(rr_q) + k) % NCORES]) begin
        push      = 1'b1;
        grant_idx = CORE_BITS'((int'(rr_q) + k) % NCORES);
      end
    end
    if (!space) begin
      push      = 1'b0;
      grant_idx = '0;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (push) begin
      if (int'(grant_idx) == NCORES - 1) begin
        rr_d = '0;
      end else begin
        rr_d = grant_idx + CORE_BITS'(1);
      end
    end
  end

  // A granted core is freed first, so a same-cycle hit refills it cleanly.
  always_comb begin
    pending_d = pending_q;
    pnonce_d  = pnonce_q;
    drops     = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (push && (grant_idx == CORE_BITS'(i))) begin
        pending_d[i] = 1'b0;
      end
      if (gn_match[i]) begin
        if (!pending_d[i]) begin
          pending_d[i] = 1'b1;
          pnonce_d[i]  = golden_nonce_in[32*i +: 32];
        end else begin
          drops = drops + 4'd1;
        end
      end
    end
  end

  assign drop_sum = {1'b0, drop_q} + 9'(drops);
  assign drop_d   = drop_sum[8] ? 8'hff : drop_sum[7:0];

  assign wr_d  = wr_q + PTR_BITS'(push);
  assign rd_d  = rd_q + PTR_BITS'(pop_eff);
  assign cnt_d = cnt_q + CNT_BITS'(push) - CNT_BITS'(pop_eff);

  assign push_ent.core  = grant_idx;
  assign push_ent.nonce = pnonce_q[grant_idx];

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      pending_q <= '0;
      rr_q      <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      drop_q    <= '0;
      for (int i = 0; i < NCORES; i++) begin
        pnonce_q[i] <= '0;
      end
    end else if (flush) begin
      pending_q <= '0;
      rr_q      <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < NCORES; i++) begin
        pnonce_q[i] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      rr_q      <= rr_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
      for (int i = 0; i < NCORES; i++) begin
        pnonce_q[i] <= pnonce_d[i];
      end
    end
  end

  // Storage needs no reset: every read of it is masked by nonce_valid.
  always_ff @(posedge hash_clk) begin
    if (push && !reset && !flush) begin
      mem_q[wr_q] <= push_ent;
    end
  end

  assign head       = mem_q[rd_q];
  assign nonce_out  = nonce_valid ? head.nonce : '0;
  assign core_id    = nonce_valid ? head.core : '0;
  assign fifo_count = cnt_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_nonce_result_arbiter.sv
// tb_nonce_result_arbiter: table vectors, directed corner sequences and
// random traffic against a queue-based reference of the arbiter.
module tb_nonce_result_arbiter;
  localparam int NC    = 2;
  localparam int DEPTH = 4;

  logic             hash_clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             pop = 1'b0;
  logic [NC-1:0]    gn_match = '0;
  logic [32*NC-1:0] golden_nonce_in = '0;
  logic             nonce_valid;
  logic [31:0]      nonce_out;
  logic             core_id;
  logic [2:0]       fifo_count;
  logic [7:0]       drop_count;

  nonce_result_arbiter #(.NCORES(NC), .DEPTH(DEPTH)) dut (
    .hash_clk        (hash_clk),
    .reset           (reset),
    .flush           (flush),
    .gn_match        (gn_match),
    .golden_nonce_in (golden_nonce_in),
    .pop             (pop),
    .nonce_valid     (nonce_valid),
    .nonce_out       (nonce_out),
    .core_id         (core_id),
    .fifo_count      (fifo_count),
    .drop_count      (drop_count)
  );

  always #5 hash_clk = ~hash_clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          core;
    logic [31:0] n;
  } ent_t;

  ent_t        mq[$];
  bit          pend[NC];
  logic [31:0] pn[NC];
  int          rr = 0;
  int          mdrop = 0;

  typedef struct {
    logic [1:0]  m;
    logic [31:0] n0;
    logic [31:0] n1;
    logic        p;
    logic        ev;
    logic [31:0] en;
    logic        ec;
    logic [2:0]  cnt;
    logic [7:0]  dr;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic model_step(input bit rs, input bit fl, input bit [1:0] m,
                            input logic [31:0] a, input logic [31:0] b,
                            input bit p);
    int g;
    bit pe;
    bit sp;
    logic [31:0] nv[NC];
    nv[0] = a;
    nv[1] = b;
    if (rs || fl) begin
      mq.delete();
      rr = 0;
      for (int i = 0; i < NC; i++) begin
        pend[i] = 0;
        pn[i] = '0;
      end
      if (rs) mdrop = 0;
      return;
    end
    pe = p && (mq.size() > 0);
    sp = (mq.size() < DEPTH) || pe;
    g = -1;
    if (sp) begin
      for (int k = 0; k < NC; k++) begin
        if (g < 0 && pend[(rr + k) % NC]) g = (rr + k) % NC;
      end
    end
    if (pe) void'(mq.pop_front());
    if (g >= 0) begin
      mq.push_back('{g, pn[g]});
      pend[g] = 0;
      rr = (g + 1) % NC;
    end
    for (int i = 0; i < NC; i++) begin
      if (m[i]) begin
        if (!pend[i]) begin
          pend[i] = 1;
          pn[i] = nv[i];
        end else if (mdrop < 255) begin
          mdrop++;
        end
      end
    end
  endtask

  task automatic compare_model();
    logic [31:0] en;
    logic [31:0] ec;
    en = '0;
    ec = '0;
    if (mq.size() > 0) begin
      en = mq[0].n;
      ec = 32'(mq[0].core);
    end
    chk("model.valid", 32'(nonce_valid), 32'(mq.size() > 0));
    chk("model.nonce", nonce_out, en);
    chk("model.core", 32'(core_id), ec);
    chk("model.count", 32'(fifo_count), 32'(mq.size()));
    chk("model.drop", 32'(drop_count), 32'(mdrop));
  endtask

  task automatic step(input bit [1:0] m, input logic [31:0] a,
                      input logic [31:0] b, input bit p,
                      input bit fl, input bit rs);
    @(negedge hash_clk);
    gn_match = m;
    golden_nonce_in = {b, a};
    pop = p;
    flush = fl;
    reset = rs;
    @(posedge hash_clk);
    model_step(rs, fl, m, a, b, p);
    #1;
    compare_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_state(input string tag, input logic v,
                              input logic [31:0] n, input logic c,
                              input logic [2:0] cnt, input logic [7:0] dr);
    chk({tag, ".valid"}, 32'(nonce_valid), 32'(v));
    chk({tag, ".nonce"}, nonce_out, n);
    chk({tag, ".core"}, 32'(core_id), 32'(c));
    chk({tag, ".count"}, 32'(fifo_count), 32'(cnt));
    chk({tag, ".drop"}, 32'(drop_count), 32'(dr));
  endtask

  initial begin
    tbl[0]  = '{2'b01, 32'h0000318f, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 8'd0};
    tbl[1]  = '{2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000318f, 1'b0, 3'd1, 8'd0};
    tbl[2]  = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 8'd0};
    tbl[3]  = '{2'b11, 32'haaaa0001, 32'hbbbb0002, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 8'd0};
    tbl[4]  = '{2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hbbbb0002, 1'b1, 3'd1, 8'd0};
    tbl[5]  = '{2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hbbbb0002, 1'b1, 3'd2, 8'd0};
    tbl[6]  = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'haaaa0001, 1'b0, 3'd1, 8'd0};
    tbl[7]  = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 8'd0};
    tbl[8]  = '{2'b10, 32'h0, 32'hcccc0003, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 8'd0};
    tbl[9]  = '{2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hcccc0003, 1'b1, 3'd1, 8'd0};
    tbl[10] = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 8'd0};
    tbl[11] = '{2'b11, 32'hdddd0004, 32'heeee0005, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 8'd0};
    tbl[12] = '{2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hdddd0004, 1'b0, 3'd1, 8'd0};
    tbl[13] = '{2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hdddd0004, 1'b0, 3'd2, 8'd0};
    tbl[14] = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'heeee0005, 1'b1, 3'd1, 8'd0};
    tbl[15] = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 8'd0};

    step(2'b00, '0, '0, 1'b0, 1'b0, 1'b1);
    step(2'b00, '0, '0, 1'b0, 1'b0, 1'b1);
    expect_state("reset", 1'b0, 32'h0, 1'b0, 3'd0, 8'd0);

    for (int r = 0; r < 16; r++) begin
      step(tbl[r].m, tbl[r].n0, tbl[r].n1, tbl[r].p, 1'b0, 1'b0);
      expect_state($sformatf("tbl%0d", r), tbl[r].ev, tbl[r].en,
                   tbl[r].ec, tbl[r].cnt, tbl[r].dr);
    end

    // back-to-back hits on one core while granted
    step(2'b01, 32'hf1f1f1f1, '0, 1'b0, 1'b0, 1'b0);
    step(2'b01, 32'hf2f2f2f2, '0, 1'b0, 1'b0, 1'b0);
    expect_state("b2b.first", 1'b1, 32'hf1f1f1f1, 1'b0, 3'd1, 8'd0);
    idle(1);
    expect_state("b2b.second", 1'b1, 32'hf1f1f1f1, 1'b0, 3'd2, 8'd0);
    step(2'b00, '0, '0, 1'b1, 1'b0, 1'b0);
    expect_state("b2b.pop", 1'b1, 32'hf2f2f2f2, 1'b0, 3'd1, 8'd0);
    step(2'b00, '0, '0, 1'b1, 1'b0, 1'b0);

    // fill, hold one pending, drop one, pop at full
    for (int h = 0; h < 4; h++) begin
      step((h % 2 == 0) ? 2'b01 : 2'b10, 32'h40000000 + h,
           32'h40000000 + h, 1'b0, 1'b0, 1'b0);
      idle(2);
    end
    expect_state("full", 1'b1, 32'h40000000, 1'b0, 3'd4, 8'd0);
    step(2'b01, 32'h40000004, '0, 1'b0, 1'b0, 1'b0);
    idle(2);
    expect_state("full.pend", 1'b1, 32'h40000000, 1'b0, 3'd4, 8'd0);
    step(2'b01, 32'h40000005, '0, 1'b0, 1'b0, 1'b0);
    expect_state("full.drop", 1'b1, 32'h40000000, 1'b0, 3'd4, 8'd1);
    idle(1);
    step(2'b00, '0, '0, 1'b1, 1'b0, 1'b0);
    expect_state("full.poppush", 1'b1, 32'h40000001, 1'b1, 3'd4, 8'd1);
    step(2'b00, '0, '0, 1'b1, 1'b0, 1'b0);
    expect_state("drain1", 1'b1, 32'h40000002, 1'b0, 3'd3, 8'd1);
    step(2'b00, '0, '0, 1'b1, 1'b0, 1'b0);
    expect_state("drain2", 1'b1, 32'h40000003, 1'b1, 3'd2, 8'd1);
    step(2'b00, '0, '0, 1'b1, 1'b0, 1'b0);
    expect_state("drain3", 1'b1, 32'h40000004, 1'b0, 3'd1, 8'd1);
    step(2'b00, '0, '0, 1'b1, 1'b0, 1'b0);
    expect_state("drain4", 1'b0, 32'h0, 1'b0, 3'd0, 8'd1);

    // flush with a hit in the same cycle
    step(2'b01, 32'h60000000, '0, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(2'b10, '0, 32'h60000001, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(2'b01, 32'h60000002, '0, 1'b0, 1'b0, 1'b0);
    idle(1);
    expect_state("preflush", 1'b1, 32'h60000000, 1'b0, 3'd3, 8'd1);
    step(2'b10, '0, 32'h60000003, 1'b0, 1'b0, 1'b0);
    step(2'b10, '0, 32'h60000004, 1'b0, 1'b1, 1'b0);
    expect_state("flush", 1'b0, 32'h0, 1'b0, 3'd0, 8'd1);
    idle(3);
    expect_state("postflush", 1'b0, 32'h0, 1'b0, 3'd0, 8'd1);
    step(2'b00, '0, '0, 1'b0, 1'b0, 1'b1);
    expect_state("reset2", 1'b0, 32'h0, 1'b0, 3'd0, 8'd0);

    // drop counter saturation with two drops per cycle
    for (int c = 0; c < 200; c++) begin
      step(2'b11, 32'h5a000000 + c, 32'h5b000000 + c, 1'b0, 1'b0, 1'b0);
    end
    expect_state("sat", 1'b1, 32'h5a000000, 1'b0, 3'd4, 8'd255);
    step(2'b00, '0, '0, 1'b0, 1'b0, 1'b1);

    for (int c = 0; c < 600; c++) begin
      bit [1:0] m;
      bit p;
      m[0] = ($urandom_range(0, 2) == 0);
      m[1] = ($urandom_range(0, 2) == 0);
      p = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      step(m, $urandom, $urandom, p, $urandom_range(0, 39) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
